// File: rtl/cy_tlb_fill_ctrl.sv
// cy_tlb_fill_ctrl
// Miss-service sequencer for the 4K/2M/4G translation TLB. A TLB miss is
// captured and reported to the host through irq_o. The host stages
// replacement entries through the cfg register port and commits them. The
// entries are then drained into the TLB write port, and the TLB is told to
// retry with resume_o. Entries can also be preloaded while no miss is pending.

module cy_tlb_fill_ctrl #(
   parameter int STAGE_LD = 3,
   parameter int TLB_AW   = 16,
   parameter int TMO_W    = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_i,
   input  logic [63:0]       miss_vaddr_i,
   input  logic              miss_read_i,
   input  logic              cfg_valid_i,
   input  logic              cfg_is_write_i,
   input  logic [7:0]        cfg_addr_i,
   input  logic [63:0]       cfg_data_i,
   output logic              cfg_rvalid_o,
   output logic [63:0]       cfg_rdata_o,
   output logic              tlb_wr_o,
   output logic [TLB_AW-1:0] tlb_wr_addr_o,
   output logic [63:0]       tlb_wr_data_o,
   input  logic              tlb_wr_ready_i,
   output logic              resume_o,
   output logic              irq_o,
   output logic              busy_o
);

   localparam int DEPTH = 2 ** STAGE_LD;
   localparam int EW    = TLB_AW + 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MWAIT  = 3'd1,
      DRAIN  = 3'd2,
      RESUME = 3'd3,
      GUARD  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                from_miss_q, from_miss_d;
   logic [EW-1:0]       mem_q [DEPTH];
   logic [STAGE_LD-1:0] wr_ptr_q, wr_ptr_d;
   logic [STAGE_LD-1:0] rd_ptr_q, rd_ptr_d;
   logic [STAGE_LD:0]   count_q, count_d;
   logic [TLB_AW-1:0]   pend_addr_q, pend_addr_d;
   logic [63:1]         vaddr_cap_q, vaddr_cap_d;
   logic                read_cap_q, read_cap_d;
   logic [15:0]         miss_cnt_q, miss_cnt_d;
   logic [TMO_W-1:0]    tmr_q, tmr_d;
   logic                tmo_q, tmo_d;
   logic                ovf_q, ovf_d;
   logic                rej_q, rej_d;
   logic                cfg_rvalid_q, cfg_rvalid_d;
   logic [63:0]         cfg_rdata_q, cfg_rdata_d;

   logic                cfg_wr;
   logic                cfg_rd;
   logic                do_latch;
   logic                do_push;
   logic                do_commit;
   logic                do_abort;
   logic                fifo_empty;
   logic                fifo_full;
   logic                push_en;
   logic                pop_en;
   logic                flush_en;
   logic [EW-1:0]       head;
   logic [63:0]         status_word;
   logic                unused_vaddr_lsb;

   assign cfg_wr     = cfg_valid_i && cfg_is_write_i;
   assign cfg_rd     = cfg_valid_i && !cfg_is_write_i;
   assign do_latch   = cfg_wr && (cfg_addr_i == 8'h08);
   assign do_push    = cfg_wr && (cfg_addr_i == 8'h10);
   assign do_commit  = cfg_wr && (cfg_addr_i == 8'h18);
   assign do_abort   = cfg_wr && (cfg_addr_i == 8'h20);

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (STAGE_LD+1)'(DEPTH));
   assign push_en    = do_push && (state_q != DRAIN) && !fifo_full;
   assign pop_en     = (state_q == DRAIN) && !fifo_empty && tlb_wr_ready_i;
   assign flush_en   = do_abort && (state_q != DRAIN);
   assign head       = mem_q[rd_ptr_q];

   assign status_word = {miss_cnt_q, 37'b0, tmo_q, ovf_q, rej_q, state_q, 5'(count_q)};

   assign unused_vaddr_lsb = miss_vaddr_i[0];

   // State and control register bank, cleared by the synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         from_miss_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pend_addr_q  <= '0;
         vaddr_cap_q  <= '0;
         read_cap_q   <= 1'b0;
         miss_cnt_q   <= '0;
         tmr_q        <= '0;
         tmo_q        <= 1'b0;
         ovf_q        <= 1'b0;
         rej_q        <= 1'b0;
         cfg_rvalid_q <= 1'b0;
         cfg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         from_miss_q  <= from_miss_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pend_addr_q  <= pend_addr_d;
         vaddr_cap_q  <= vaddr_cap_d;
         read_cap_q   <= read_cap_d;
         miss_cnt_q   <= miss_cnt_d;
         tmr_q        <= tmr_d;
         tmo_q        <= tmo_d;
         ovf_q        <= ovf_d;
         rej_q        <= rej_d;
         cfg_rvalid_q <= cfg_rvalid_d;
         cfg_rdata_q  <= cfg_rdata_d;
      end
   end

   // Staging storage; only the pointers and count say which slots are live
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= {pend_addr_q, cfg_data_i};
      end
   end

   // Next-state logic of the miss-service sequence
   always_comb begin
      state_d     = state_q;
      from_miss_d = from_miss_q;
      case (state_q)
         IDLE: begin
            if (miss_i) begin
               state_d = MWAIT;
            end else if (do_commit && !fifo_empty) begin
               state_d     = DRAIN;
               from_miss_d = 1'b0;
            end
         end
         MWAIT: begin
            if (do_commit) begin
               if (!fifo_empty) begin
                  state_d     = DRAIN;
                  from_miss_d = 1'b1;
               end else begin
                  state_d = RESUME;
               end
            end
         end
         DRAIN: begin
            if (pop_en && (count_q == (STAGE_LD+1)'(1))) begin
               state_d = from_miss_q ? RESUME : IDLE;
            end
         end
         RESUME: state_d = GUARD;
         GUARD:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Staging buffer pointers, miss capture, timeout timer and sticky flags
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pend_addr_d = pend_addr_q;
      vaddr_cap_d = vaddr_cap_q;
      read_cap_d  = read_cap_q;
      miss_cnt_d  = miss_cnt_q;
      tmr_d       = tmr_q;
      tmo_d       = tmo_q;
      ovf_d       = ovf_q;
      rej_d       = rej_q;

      if (do_latch) begin
         pend_addr_d = cfg_data_i[TLB_AW-1:0];
      end

      if ((state_q == IDLE) && miss_i) begin
         vaddr_cap_d = miss_vaddr_i[63:1];
         read_cap_d  = miss_read_i;
         if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
         end
         tmo_d = 1'b0;
         tmr_d = '0;
      end

      if (state_q == MWAIT) begin
         if (&tmr_q) begin
            tmo_d = 1'b1;
         end else begin
            tmr_d = tmr_q + TMO_W'(1);
         end
      end

      if (do_commit && (((state_q == IDLE) && miss_i) ||
                        (state_q == RESUME) || (state_q == GUARD))) begin
         rej_d = 1'b1;
      end
      if ((do_push || do_abort) && (state_q == DRAIN)) begin
         rej_d = 1'b1;
      end
      if (do_push && (state_q != DRAIN) && fifo_full) begin
         ovf_d = 1'b1;
      end

      if (flush_en) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         rej_d    = 1'b0;
         tmo_d    = 1'b0;
      end else begin
         if (push_en) begin
            wr_ptr_d = wr_ptr_q + STAGE_LD'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + STAGE_LD'(1);
         end
         count_d = count_q + (STAGE_LD+1)'(push_en) - (STAGE_LD+1)'(pop_en);
      end
   end

   // Register read path: data is sampled at the strobe and returned a cycle later
   always_comb begin
      cfg_rvalid_d = cfg_rd;
      cfg_rdata_d  = '0;
      if (cfg_rd) begin
         case (cfg_addr_i)
            8'h00:   cfg_rdata_d = status_word;
            8'h28:   cfg_rdata_d = {vaddr_cap_q, read_cap_q};
            default: cfg_rdata_d = '0;
         endcase
      end
   end

   // Outputs decoded from the current state and the buffer head
   always_comb begin
      tlb_wr_o      = 1'b0;
      tlb_wr_addr_o = '0;
      tlb_wr_data_o = '0;
      resume_o      = 1'b0;
      irq_o         = 1'b0;
      busy_o        = (state_q != IDLE);
      cfg_rvalid_o  = cfg_rvalid_q;
      cfg_rdata_o   = cfg_rdata_q;
      case (state_q)
         MWAIT:  irq_o = 1'b1;
         DRAIN: begin
            if (!fifo_empty) begin
               tlb_wr_o      = 1'b1;
               tlb_wr_addr_o = head[EW-1:64];
               tlb_wr_data_o = head[63:0];
            end
         end
         RESUME: resume_o = 1'b1;
         default: ;
      endcase
   end

endmodule
